// File: rtl/cmd_arb_fifo.sv
// Multi-source command arbiter feeding a small FIFO that drives the cmd_proc handshake.
// Completions are routed back as a response byte tagged with the issuing source.
module cmd_arb_fifo #(
  parameter int          NUM_SRC   = 2,
  parameter int          DEPTH     = 4,
  parameter int          ARB_MODE  = 0,
  parameter logic [7:0]  RESP_DONE = 8'hA5,
  parameter logic [7:0]  RESP_BUSY = 8'h5A,
  localparam int         SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [16*NUM_SRC-1:0]  src_cmd,
  input  logic [NUM_SRC-1:0]     src_vld,
  output logic [NUM_SRC-1:0]     src_ack,
  output logic [15:0]            cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   send_resp,
  output logic [7:0]             resp,
  output logic [SRC_W-1:0]       resp_src,
  output logic                   resp_vld,
  output logic [CNT_W-1:0]       cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = SRC_W + 16;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_cnt;
  logic [SRC_W-1:0]   r_inflightId;
  logic [SRC_W-1:0]   r_rrPtr;
  logic [7:0]         r_resp;
  logic [SRC_W-1:0]   r_respSrc;
  logic               r_respVld;

  logic               w_grantFound;
  logic [SRC_W-1:0]   w_grantIdx;
  logic [15:0]        w_grantCmd;
  logic [SRC_W-1:0]   w_rrNext;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  int                 w_searchIdx;

  // Grant search: fixed mode scans from index 0, round robin scans from r_rrPtr and wraps.
  always_comb begin
    w_grantFound = 1'b0;
    w_grantIdx   = '0;
    w_grantCmd   = '0;
    w_searchIdx  = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ARB_MODE == 1) begin
        w_searchIdx = (int'(r_rrPtr) + k) % NUM_SRC;
      end else begin
        w_searchIdx = k;
      end
      if (!w_grantFound && src_vld[w_searchIdx]) begin
        w_grantFound = 1'b1;
        w_grantIdx   = SRC_W'(w_searchIdx);
        w_grantCmd   = src_cmd[16*w_searchIdx +: 16];
      end
    end
  end

  assign w_head   = r_mem[r_rdPtr];
  assign w_full   = (r_cnt == CNT_W'(DEPTH));
  assign w_pop    = clr_cmd_rdy && (r_cnt != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push   = w_grantFound && (!w_full || clr_cmd_rdy);
  assign w_rrNext = (w_grantIdx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grantIdx + 1'b1;

  always_comb begin
    src_ack = '0;
    if (w_push && rst_n) begin
      src_ack[w_grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_cnt        <= '0;
      r_inflightId <= '0;
      r_rrPtr      <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {w_grantIdx, w_grantCmd};
        r_wrPtr        <= r_wrPtr + 1'b1;
        r_rrPtr        <= w_rrNext;
      end
      if (w_pop) begin
        r_rdPtr      <= r_rdPtr + 1'b1;
        r_inflightId <= w_head[ENTRY_W-1:16];
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Response uses the pre-pop inflight ID and pre-update occupancy of the send_resp cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp    <= RESP_BUSY;
      r_respSrc <= '0;
      r_respVld <= 1'b0;
    end else begin
      r_respVld <= send_resp;
      if (send_resp) begin
        r_respSrc <= r_inflightId;
        r_resp    <= ((r_cnt == '0) && !(|src_vld)) ? RESP_DONE : RESP_BUSY;
      end
    end
  end

  assign cmd      = (r_cnt != '0) ? w_head[15:0] : 16'h0000;
  assign cmd_rdy  = (r_cnt != '0);
  assign cnt      = r_cnt;
  assign resp     = r_resp;
  assign resp_src = r_respSrc;
  assign resp_vld = r_respVld;

endmodule

// File: tb/tb_cmd_arb_fifo.sv
// Scoreboard bench for cmd_arb_fifo: a fixed-priority 2-source instance and a round-robin 3-source instance.
// Stimulus pushes expectations into queues; one negedge monitor pops and compares them.
module tb_cmd_arb_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] srcCmd0;
  logic [1:0]  srcVld0, srcAck0;
  logic [15:0] cmd0;
  logic        cmdRdy0, clr0, send0, respSrc0, respVld0;
  logic [7:0]  resp0;
  logic [2:0]  cnt0;

  logic [47:0] srcCmd1;
  logic [2:0]  srcVld1, srcAck1;
  logic [15:0] cmd1;
  logic        cmdRdy1, clr1, send1, respVld1;
  logic [1:0]  respSrc1;
  logic [7:0]  resp1;
  logic [2:0]  cnt1;

  cmd_arb_fifo #(.NUM_SRC(2), .DEPTH(4), .ARB_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .src_cmd(srcCmd0), .src_vld(srcVld0), .src_ack(srcAck0),
    .cmd(cmd0), .cmd_rdy(cmdRdy0), .clr_cmd_rdy(clr0), .send_resp(send0),
    .resp(resp0), .resp_src(respSrc0), .resp_vld(respVld0), .cnt(cnt0)
  );

  cmd_arb_fifo #(.NUM_SRC(3), .DEPTH(4), .ARB_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .src_cmd(srcCmd1), .src_vld(srcVld1), .src_ack(srcAck1),
    .cmd(cmd1), .cmd_rdy(cmdRdy1), .clr_cmd_rdy(clr1), .send_resp(send1),
    .resp(resp1), .resp_src(respSrc1), .resp_vld(respVld1), .cnt(cnt1)
  );

  typedef struct packed {
    logic        dut;
    logic [2:0]  cnt;
    logic        rdy;
    logic [2:0]  ack;
    logic [7:0]  resp;
    logic        respVld;
    logic [15:0] cmd;
  } state_t;

  state_t      stateQ[$];
  logic [2:0]  ackQ0[$];
  logic [2:0]  ackQ1[$];
  logic [15:0] popQ0[$];
  logic [15:0] popQ1[$];
  logic [8:0]  respQ0[$];
  state_t      monSt;
  int          passCount = 0;
  int          checkCount = 0;
  bit          endReq = 1'b0;

  logic [2:0]  rrVld [8] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101, 3'b000};
  logic [2:0]  rrAck [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000};
  logic [15:0] rrPop [8] = '{16'h0000, 16'h1000, 16'h2001, 16'h3002, 16'h1003, 16'h3004, 16'h1005, 16'h3006};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expectState(input logic dut, input logic [2:0] c, input logic r, input logic [2:0] a,
                             input logic [7:0] rs, input logic rv, input logic [15:0] cm);
    stateQ.push_back('{dut, c, r, a, rs, rv, cm});
  endtask

  task automatic applyStimulus(input logic [1:0] vld, input logic clr, input logic send);
    srcVld0 = vld;
    clr0    = clr;
    send0   = send;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: snapshot checks first, then every output event is matched against its queue.
  always @(negedge clk) begin
    while (stateQ.size() > 0) begin
      monSt = stateQ.pop_front();
      if (monSt.dut == 1'b0) begin
        checkOutput("dut0 cnt", 32'(cnt0), 32'(monSt.cnt));
        checkOutput("dut0 cmd_rdy", 32'(cmdRdy0), 32'(monSt.rdy));
        checkOutput("dut0 src_ack", 32'(srcAck0), 32'(monSt.ack));
        checkOutput("dut0 resp", 32'(resp0), 32'(monSt.resp));
        checkOutput("dut0 resp_vld", 32'(respVld0), 32'(monSt.respVld));
        checkOutput("dut0 cmd", 32'(cmd0), 32'(monSt.cmd));
      end else begin
        checkOutput("dut1 cnt", 32'(cnt1), 32'(monSt.cnt));
        checkOutput("dut1 cmd_rdy", 32'(cmdRdy1), 32'(monSt.rdy));
        checkOutput("dut1 src_ack", 32'(srcAck1), 32'(monSt.ack));
        checkOutput("dut1 resp", 32'(resp1), 32'(monSt.resp));
        checkOutput("dut1 resp_vld", 32'(respVld1), 32'(monSt.respVld));
        checkOutput("dut1 cmd", 32'(cmd1), 32'(monSt.cmd));
      end
    end
    if (srcAck0 != '0) begin
      if (ackQ0.size() == 0) checkOutput("dut0 unexpected ack", 32'(srcAck0), 32'd0);
      else checkOutput("dut0 ack seq", 32'(srcAck0), 32'(ackQ0.pop_front()));
    end
    if (clr0 && cmdRdy0) begin
      if (popQ0.size() == 0) checkOutput("dut0 unexpected pop", 32'(cmd0), 32'hFFFF_FFFF);
      else checkOutput("dut0 pop cmd", 32'(cmd0), 32'(popQ0.pop_front()));
    end
    if (respVld0) begin
      if (respQ0.size() == 0) checkOutput("dut0 unexpected resp_vld", 32'(respVld0), 32'd0);
      else checkOutput("dut0 resp/resp_src", 32'({resp0, respSrc0}), 32'(respQ0.pop_front()));
    end
    if (srcAck1 != '0) begin
      if (ackQ1.size() == 0) checkOutput("dut1 unexpected ack", 32'(srcAck1), 32'd0);
      else checkOutput("dut1 ack seq", 32'(srcAck1), 32'(ackQ1.pop_front()));
    end
    if (clr1 && cmdRdy1) begin
      if (popQ1.size() == 0) checkOutput("dut1 unexpected pop", 32'(cmd1), 32'hFFFF_FFFF);
      else checkOutput("dut1 pop cmd", 32'(cmd1), 32'(popQ1.pop_front()));
    end
    if (respVld1) checkOutput("dut1 unexpected resp_vld", 32'(respVld1), 32'd0);
    if (endReq) begin
      checkOutput("dut0 acks outstanding", 32'(ackQ0.size()), 32'd0);
      checkOutput("dut1 acks outstanding", 32'(ackQ1.size()), 32'd0);
      checkOutput("dut0 pops outstanding", 32'(popQ0.size()), 32'd0);
      checkOutput("dut1 pops outstanding", 32'(popQ1.size()), 32'd0);
      checkOutput("dut0 resps outstanding", 32'(respQ0.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
    end
  end

  initial begin
    rst_n   = 1'b0;
    srcCmd0 = '0;
    srcCmd1 = '0;
    srcVld1 = '0;
    clr1    = 1'b0;
    send1   = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    expectState(1'b1, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] fixed priority, two sources at once");
    srcCmd0 = {16'h2345, 16'h4001};
    applyStimulus(2'b11, 1'b0, 1'b0);
    ackQ0.push_back(3'b001);
    expectState(1'b0, 3'd0, 1'b0, 3'b001, 8'h5A, 1'b0, 16'h0000);
    tick();
    applyStimulus(2'b10, 1'b0, 1'b0);
    ackQ0.push_back(3'b010);
    expectState(1'b0, 3'd1, 1'b1, 3'b010, 8'h5A, 1'b0, 16'h4001);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b0);
    popQ0.push_back(16'h4001);
    expectState(1'b0, 3'd2, 1'b1, 3'b000, 8'h5A, 1'b0, 16'h4001);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b0);
    popQ0.push_back(16'h2345);
    expectState(1'b0, 3'd1, 1'b1, 3'b000, 8'h5A, 1'b0, 16'h2345);
    tick();

    $display("[TB] pop on empty, then response routing");
    applyStimulus(2'b00, 1'b1, 1'b0);
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1);
    respQ0.push_back({8'hA5, 1'b1});
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'hA5, 1'b1, 16'h0000);
    tick();
    srcCmd0[31:16] = 16'h5555;
    applyStimulus(2'b10, 1'b0, 1'b0);
    ackQ0.push_back(3'b010);
    expectState(1'b0, 3'd0, 1'b0, 3'b010, 8'hA5, 1'b0, 16'h0000);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b0);
    popQ0.push_back(16'h5555);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1);
    respQ0.push_back({8'hA5, 1'b1});
    tick();
    srcCmd0[15:0] = 16'h1111;
    applyStimulus(2'b01, 1'b0, 1'b0);
    ackQ0.push_back(3'b001);
    expectState(1'b0, 3'd0, 1'b0, 3'b001, 8'hA5, 1'b1, 16'h0000);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1);
    respQ0.push_back({8'h5A, 1'b1});
    expectState(1'b0, 3'd1, 1'b1, 3'b000, 8'hA5, 1'b0, 16'h1111);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b1);
    popQ0.push_back(16'h1111);
    respQ0.push_back({8'h5A, 1'b1});
    expectState(1'b0, 3'd1, 1'b1, 3'b000, 8'h5A, 1'b1, 16'h1111);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b1, 16'h0000);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1);
    respQ0.push_back({8'hA5, 1'b0});
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();

    $display("[TB] fill to depth, push on pop, pointer wrap");
    for (int k = 0; k < 4; k++) begin
      srcCmd0[15:0] = 16'hF000 + 16'(k);
      applyStimulus(2'b01, 1'b0, k == 0);
      ackQ0.push_back(3'b001);
      if (k == 0) begin
        respQ0.push_back({8'h5A, 1'b0});
        expectState(1'b0, 3'd0, 1'b0, 3'b001, 8'hA5, 1'b0, 16'h0000);
      end
      if (k == 1) expectState(1'b0, 3'd1, 1'b1, 3'b001, 8'h5A, 1'b1, 16'hF000);
      tick();
    end
    srcCmd0[15:0] = 16'hF004;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b01, 1'b0, 1'b0);
      expectState(1'b0, 3'd4, 1'b1, 3'b000, 8'h5A, 1'b0, 16'hF000);
      tick();
    end
    applyStimulus(2'b01, 1'b1, 1'b0);
    ackQ0.push_back(3'b001);
    popQ0.push_back(16'hF000);
    expectState(1'b0, 3'd4, 1'b1, 3'b001, 8'h5A, 1'b0, 16'hF000);
    tick();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(2'b00, 1'b1, 1'b0);
      popQ0.push_back(16'hF000 + 16'(k));
      if (k == 1) expectState(1'b0, 3'd4, 1'b1, 3'b000, 8'h5A, 1'b0, 16'hF001);
      tick();
    end
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    tick();

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(2'b00, 1'b0, 1'b1);
    respQ0.push_back({8'hA5, 1'b0});
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      srcCmd0[15:0] = 16'h0A00 + 16'(k);
      applyStimulus(2'b01, 1'b0, 1'b0);
      ackQ0.push_back(3'b001);
      tick();
    end
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd3, 1'b1, 3'b000, 8'hA5, 1'b0, 16'h0A00);
    tick();
    #2;
    srcCmd0[15:0] = 16'h0B00;
    applyStimulus(2'b01, 1'b0, 1'b0);
    rst_n = 1'b0;
    expectState(1'b0, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    expectState(1'b1, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b1;
    ackQ0.push_back(3'b001);
    expectState(1'b0, 3'd0, 1'b0, 3'b001, 8'h5A, 1'b0, 16'h0000);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    expectState(1'b0, 3'd1, 1'b1, 3'b000, 8'h5A, 1'b0, 16'h0B00);
    tick();
    applyStimulus(2'b00, 1'b1, 1'b0);
    popQ0.push_back(16'h0B00);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0);
    tick();

    $display("[TB] round robin, three sources");
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 3; i++) begin
        srcCmd1[16*i +: 16] = {4'(i + 1), 12'(n)};
      end
      srcVld1 = rrVld[n];
      clr1    = 1'b1;
      if (rrAck[n] != 3'b000) ackQ1.push_back(rrAck[n]);
      if (n >= 1) popQ1.push_back(rrPop[n]);
      if (n == 0) expectState(1'b1, 3'd0, 1'b0, 3'b001, 8'h5A, 1'b0, 16'h0000);
      if (n == 4) expectState(1'b1, 3'd1, 1'b1, 3'b100, 8'h5A, 1'b0, 16'h1003);
      tick();
    end
    clr1 = 1'b0;
    expectState(1'b1, 3'd0, 1'b0, 3'b000, 8'h5A, 1'b0, 16'h0000);
    tick();

    endReq = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] FAIL monitor did not reach the summary");
    $fatal(1, "[TB] monitor stalled");
  end

endmodule

// File: doc/cmd_arb_fifo.md
Name: cmd_arb_fifo

Overview:
- Parametrised successor to the two-source UART/tour command multiplexing in the KnightsTour top level.
- Arbitrates NUM_SRC 16-bit command sources (BLE UART, TourCmd move generator, future test/auto sources) into a DEPTH-entry FIFO.
- Presents the FIFO head to cmd_proc on its existing cmd/cmd_rdy/clr_cmd_rdy handshake.
- Routes each completion (send_resp) back as an 8-bit response, tagged with the source that issued the command.

Parameters:
- NUM_SRC, 2: number of command sources, 2..8.
- DEPTH, 4: FIFO entries, power of two, 2..16.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round robin.
- RESP_DONE, 8'hA5: response when all work is finished.
- RESP_BUSY, 8'h5A: response when work remains.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_cmd  in  16*NUM_SRC  packed commands; source i occupies bits [16i+15:16i]
- src_vld  in  NUM_SRC  per-source request; held until acked
- src_ack  out  NUM_SRC  one-cycle one-hot pulse when that source's command is written into the FIFO
- cmd  out  16  FIFO head command
- cmd_rdy  out  1  FIFO non-empty
- clr_cmd_rdy  in  1  pop strobe from cmd_proc
- send_resp  in  1  completion strobe from cmd_proc
- resp  out  8  response byte
- resp_src  out  SRC_W  source ID of the completed command; SRC_W = max(1, clog2(NUM_SRC))
- resp_vld  out  1  one-cycle pulse accompanying resp/resp_src
- cnt  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n low): FIFO empty, cnt=0, cmd_rdy=0, cmd=0, src_ack=0, resp=RESP_BUSY, resp_src=0, resp_vld=0, inflight ID=0, round-robin pointer=0. All registers async-reset.
- Storage:
  - Each entry holds {src_id, cmd[15:0]}.
  - Write and read pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - cnt is a separate counter.
- Arbitration (combinational grant, registered write):
  - A grant occurs in a cycle when any src_vld is high and the FIFO is not full, or is full but clr_cmd_rdy is high that cycle (push-on-pop allowed).
  - The granted source's src_ack pulses in the same cycle as the write.
  - The entry becomes visible at the head at the earliest the next cycle. Latency from src_vld to cmd_rdy on an empty FIFO is 1 clock.
  - Only one grant per cycle.
- ARB_MODE=0: lowest asserted index wins.
- ARB_MODE=1:
  - The search starts at rr_ptr and wraps.
  - After a grant, rr_ptr = granted+1 mod NUM_SRC.
  - rr_ptr is unchanged when there is no grant.
- Source-side rules:
  - A source whose src_vld drops before its ack is simply not granted; no error.
  - The same source may be granted on consecutive cycles if it re-asserts.
- Pop:
  - clr_cmd_rdy with cnt>0 advances the read pointer and latches the head's src_id into inflight_id.
  - clr_cmd_rdy with cnt==0 is ignored; pointers, cnt and inflight_id are unchanged.
- Simultaneous push and pop: cnt unchanged and both pointers advance.
  - When cnt==0, push+pop is impossible because pop is ignored; the push proceeds normally.
- cmd_rdy = (cnt != 0), registered-equivalent. cmd = head data, or 0 when empty.
- Response: on send_resp, register for one cycle:
  - resp_vld=1
  - resp_src=inflight_id
  - resp = RESP_DONE if cnt==0 and no src_vld is asserted in the send_resp cycle; otherwise RESP_BUSY.
  - resp and resp_src hold until the next send_resp. resp_vld is a single-cycle pulse.
- send_resp coinciding with clr_cmd_rdy: the response uses the inflight_id value from before the pop.
  - The response is evaluated on pre-push/pre-pop cnt of that cycle.
- Mid-operation reset: all state clears immediately; pending src_vld is re-arbitrated after rst_n deasserts.
- Width rules: cnt saturates logically at DEPTH (cannot exceed by construction). Pointer arithmetic wraps naturally.

Test Plan:
- NUM_SRC=2, ARB_MODE=0, empty FIFO; src_vld=2'b11, src_cmd={16'h2345,16'h4001}:
  - cycle 0: src_ack=01.
  - cycle 1: src_ack=10, cmd=16'h4001, cmd_rdy=1.
  - After two pops cmd_rdy=0, cnt=0.
- Fill: DEPTH=4, hold src_vld[0] with no pops:
  - Exactly 4 acks, cnt=4, no 5th ack.
  - Pulse clr_cmd_rdy: 5th ack occurs that same cycle, cnt stays 4.
  - Read pointer wraps: commands pop in order 0..4.
- ARB_MODE=1, NUM_SRC=3, all src_vld held:
  - Acks rotate 001,010,100,001.
  - Drop src_vld[1]: acks go 100→001→100.
- Response routing:
  - Queue src1 cmd 16'h5555, pop it, fifo empty, src_vld=0, pulse send_resp → next cycle resp_vld=1, resp=8'hA5, resp_src=1.
  - Repeat with another command queued → resp=8'h5A.
- Edge cases:
  - clr_cmd_rdy with empty FIFO: cnt stays 0, inflight_id unchanged.
  - send_resp and clr_cmd_rdy in the same cycle: resp_src reports the previous inflight source.
- Reset mid-stream: cnt=3, assert rst_n low asynchronously between clock edges:
  - Immediately cmd_rdy=0, cnt=0, resp=8'h5A.
  - After release, a held src_vld is acked on the first clock.
